// File: rtl/multi_cycle_shift_register_pkg.sv
// Shared encodings for the serial multi-cycle shifter and its single-step core.
package multi_cycle_shift_register_pkg;

    localparam int unsigned MODE_WIDTH = 3;

    // Operation encodings presented on Mode; 110/111 behave as hold.
    localparam logic [MODE_WIDTH-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_WIDTH-1:0] MODE_SLL  = 3'b001;
    localparam logic [MODE_WIDTH-1:0] MODE_SRL  = 3'b010;
    localparam logic [MODE_WIDTH-1:0] MODE_SRA  = 3'b011;
    localparam logic [MODE_WIDTH-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_WIDTH-1:0] MODE_ROR  = 3'b101;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True for modes that actually move bits (and therefore update SerialOut).
    function automatic logic is_shift_mode(input logic [MODE_WIDTH-1:0] mode);
        return (mode == MODE_SLL) || (mode == MODE_SRL) || (mode == MODE_SRA) ||
               (mode == MODE_ROL) || (mode == MODE_ROR);
    endfunction

endpackage

// File: rtl/multi_cycle_shift_register_shift_step.sv
// One-position shift/rotate step; purely combinational so a barrel shifter can reuse it.
module multi_cycle_shift_register_shift_step
    import multi_cycle_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]      value,
    input  logic [MODE_WIDTH-1:0] mode,
    output logic [WIDTH-1:0]      next_value,
    output logic                  out_bit
);

    // Select the single-step result and the bit that leaves the register.
    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            MODE_SLL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                out_bit    = value[WIDTH-1];
            end
            MODE_SRL: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_SRA: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            MODE_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_shift_register.sv
// Low-area serial shifter: parallel load, then one bit position per clock with Start/Busy/Done.
module multi_cycle_shift_register
    import multi_cycle_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned AMOUNT_WIDTH = 5
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Load,
    input  logic [WIDTH-1:0]        Data,
    input  logic                    Start,
    input  logic [MODE_WIDTH-1:0]   Mode,
    input  logic [AMOUNT_WIDTH-1:0] Amount,
    output logic [WIDTH-1:0]        Q,
    output logic                    SerialOut,
    output logic                    Busy,
    output logic                    Done
);

    state_e                  state;
    logic [MODE_WIDTH-1:0]   mode_r;
    logic [AMOUNT_WIDTH-1:0] count;
    logic [WIDTH-1:0]        step_value;
    logic                    step_bit;

    multi_cycle_shift_register_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value     (Q),
        .mode      (mode_r),
        .next_value(step_value),
        .out_bit   (step_bit)
    );

    // Sequencer, down-counter and data registers; Busy/Done track the next state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_HOLD;
            count     <= '0;
            Q         <= '0;
            SerialOut <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    Q     <= step_value;
                    count <= count - AMOUNT_WIDTH'(1);
                    if (is_shift_mode(mode_r)) begin
                        SerialOut <= step_bit;
                    end
                    if (count == AMOUNT_WIDTH'(1)) begin
                        state <= ST_DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE accept new work; Load wins over Start.
                    if (Load) begin
                        Q     <= Data;
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b0;
                    end else if (Start) begin
                        mode_r <= Mode;
                        count  <= Amount;
                        if (Amount != '0) begin
                            state <= ST_SHIFT;
                            Busy  <= 1'b1;
                            Done  <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_shift_register.sv
// Scoreboard bench for the serial shifter at WIDTH=8.
module tb_multi_cycle_shift_register;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 3;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SLL  = 3'b001;
    localparam logic [2:0] M_SRL  = 3'b010;
    localparam logic [2:0] M_SRA  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;

    logic          Clock;
    logic          Reset;
    logic          Load;
    logic [W-1:0]  Data;
    logic          Start;
    logic [2:0]    Mode;
    logic [AW-1:0] Amount;
    logic [W-1:0]  Q;
    logic          SerialOut;
    logic          Busy;
    logic          Done;

    typedef struct packed {
        logic [W-1:0] q;
        logic         so;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] m_q      = '0;
    logic         m_so     = 1'b0;

    multi_cycle_shift_register #(
        .WIDTH       (W),
        .AMOUNT_WIDTH(AW)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (Load),
        .Data     (Data),
        .Start    (Start),
        .Mode     (Mode),
        .Amount   (Amount),
        .Q        (Q),
        .SerialOut(SerialOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: apply n single-position steps of the given mode.
    function automatic void ref_op(input logic [W-1:0] q_in, input logic so_in,
                                   input logic [2:0] mode, input int n,
                                   output logic [W-1:0] q_out, output logic so_out);
        logic [W-1:0]        q;
        logic signed [W-1:0] s;
        logic                so;
        q  = q_in;
        so = so_in;
        for (int i = 0; i < n; i++) begin
            case (mode)
                M_SLL: begin so = q[W-1]; q = q << 1; end
                M_SRL: begin so = q[0];   q = q >> 1; end
                M_SRA: begin so = q[0];   s = q; s = s >>> 1; q = s; end
                M_ROL: begin so = q[W-1]; q = (q << 1) | (q >> (W-1)); end
                M_ROR: begin so = q[0];   q = (q >> 1) | (q << (W-1)); end
                default: ;
            endcase
        end
        q_out  = q;
        so_out = so;
    endfunction

    // Scoreboard: every Done pulse must match the oldest pending result.
    always @(negedge Clock) begin
        if (!Reset && Done) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL done_unexpected: Done=1 with no pending operation, Q=%h", Q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (Q !== e.q || SerialOut !== e.so)
                    $display("FAIL result: Q=%h SerialOut=%b, required Q=%h SerialOut=%b",
                             Q, SerialOut, e.q, e.so);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] d);
        Load = 1'b1;
        Data = d;
        tick();
        Load = 1'b0;
        Data = 8'($urandom_range(0, 255));
        m_q  = d;
        n_checks++;
        if (Q !== d || SerialOut !== m_so || Busy !== 1'b0 || Done !== 1'b0)
            $display("FAIL load: Q=%h so=%b busy=%b done=%b, required Q=%h so=%b busy=0 done=0",
                     Q, SerialOut, Busy, Done, d, m_so);
        else
            n_pass++;
    endtask

    // Start an operation, push its expected result, and stop in the Done cycle.
    task automatic run_op(input logic [2:0] mode, input logic [AW-1:0] amt);
        logic [W-1:0] nq;
        logic         nso;
        int           busy_cnt;
        ref_op(m_q, m_so, mode, int'(amt), nq, nso);
        m_q  = nq;
        m_so = nso;
        sb.push_back('{q: nq, so: nso});
        Start  = 1'b1;
        Mode   = mode;
        Amount = amt;
        tick();
        Start  = 1'b0;
        Mode   = 3'($urandom_range(0, 7));
        Amount = 3'($urandom_range(0, 7));
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (Done) break;
            if (Busy) busy_cnt++;
            tick();
        end
        n_checks++;
        if (Done !== 1'b1 || Busy !== 1'b0)
            $display("FAIL done_timeout: done=%b busy=%b, required done=1 busy=0", Done, Busy);
        else
            n_pass++;
        n_checks++;
        if (busy_cnt != int'(amt))
            $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, amt);
        else
            n_pass++;
    endtask

    task automatic end_pulse();
        tick();
        n_checks++;
        if (Done !== 1'b0 || Busy !== 1'b0)
            $display("FAIL done_pulse_width: done=%b busy=%b, required 0 0", Done, Busy);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Start  = 1'b1;
        Load   = 1'b0;
        Data   = '0;
        Mode   = M_SLL;
        Amount = 3'd3;
        tick();
        tick();
        if (Q !== 8'h00)      $display("FAIL reset_q: Q=%h, required 00", Q);
        else                  n_pass++;
        if (SerialOut !== 1'b0) $display("FAIL reset_so: so=%b, required 0", SerialOut);
        else                  n_pass++;
        if (Busy !== 1'b0)    $display("FAIL reset_busy: busy=%b, required 0", Busy);
        else                  n_pass++;
        if (Done !== 1'b0)    $display("FAIL reset_done: done=%b, required 0", Done);
        else                  n_pass++;
        n_checks += 4;
        Reset = 1'b0;
        Start = 1'b0;
        m_q   = '0;
        m_so  = 1'b0;
        tick();
    endtask

    task automatic test_sll();
        do_load(8'hB4);
        run_op(M_SLL, 3'd3);
        n_checks++;
        if (Q !== 8'hA0 || SerialOut !== 1'b1)
            $display("FAIL sll_value: Q=%h so=%b, required A0 1", Q, SerialOut);
        else
            n_pass++;
        end_pulse();
    endtask

    task automatic test_sra();
        do_load(8'h96);
        run_op(M_SRA, 3'd2);
        n_checks++;
        if (Q !== 8'hE5 || SerialOut !== 1'b1)
            $display("FAIL sra_value: Q=%h so=%b, required E5 1", Q, SerialOut);
        else
            n_pass++;
        end_pulse();
    endtask

    task automatic test_back_to_back();
        do_load(8'h81);
        run_op(M_ROR, 3'd7);
        n_checks++;
        if (Q !== 8'h03 || SerialOut !== 1'b0)
            $display("FAIL ror_value: Q=%h so=%b, required 03 0", Q, SerialOut);
        else
            n_pass++;
        // Start issued in the Done cycle; Busy must rise on the very next edge.
        run_op(M_ROL, 3'd1);
        n_checks++;
        if (Q !== 8'h06 || SerialOut !== 1'b0)
            $display("FAIL rol_value: Q=%h so=%b, required 06 0", Q, SerialOut);
        else
            n_pass++;
        end_pulse();
    endtask

    task automatic test_zero_amount();
        do_load(8'h5A);
        run_op(M_SLL, 3'd0);
        n_checks++;
        if (Q !== 8'h5A)
            $display("FAIL zero_amount: Q=%h, required 5A", Q);
        else
            n_pass++;
        end_pulse();
    endtask

    task automatic test_hold_mode();
        do_load(8'h3C);
        run_op(3'b110, 3'd4);
        end_pulse();
        do_load(8'hC3);
        run_op(M_HOLD, 3'd2);
        end_pulse();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_load(8'($urandom_range(0, 255)));
            run_op(3'($urandom_range(1, 5)), 3'($urandom_range(0, 7)));
            if (i % 2 == 0) end_pulse();
            else run_op(3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)));
            if (i % 2 == 1) end_pulse();
        end
    endtask

    task automatic test_abort();
        int done_cnt;
        do_load(8'hFF);
        Start  = 1'b1;
        Mode   = M_SRL;
        Amount = 3'd7;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (Q !== 8'h1F || Busy !== 1'b1)
            $display("FAIL abort_mid: Q=%h busy=%b, required 1F 1", Q, Busy);
        else
            n_pass++;
        Start  = 1'b1;
        Load   = 1'b1;
        Data   = 8'h00;
        Mode   = M_SLL;
        Amount = 3'd1;
        tick();
        Start = 1'b0;
        Load  = 1'b0;
        n_checks++;
        if (Q !== 8'h0F || Busy !== 1'b1)
            $display("FAIL ignored_in_shift: Q=%h busy=%b, required 0F 1", Q, Busy);
        else
            n_pass++;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_q   = '0;
        m_so  = 1'b0;
        n_checks++;
        if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || SerialOut !== 1'b0)
            $display("FAIL abort_reset: Q=%h busy=%b done=%b so=%b, required 00 0 0 0",
                     Q, Busy, Done, SerialOut);
        else
            n_pass++;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (Done || Busy) done_cnt++;
            tick();
        end
        n_checks++;
        if (done_cnt != 0)
            $display("FAIL abort_no_done: saw Busy/Done in %0d cycles, required 0", done_cnt);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra();
        test_back_to_back();
        test_zero_amount();
        test_hold_mode();
        test_random();
        test_abort();
        tick();
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: %0d results never produced, required 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_shift_register.md
Name: multi_cycle_shift_register

Overview:
- Parametrised, mode-selectable shift register for the RISC-V datapath; performs SLL/SRL/SRA/ROL/ROR by a programmable amount, one bit position per clock.
- Successor to the single-bit D flip-flop storage element: WIDTH-bit parallel load, multi-cycle shift sequencing with Start/Busy/Done handshake, and serial-out tap.
- Sits beside the ALU as the low-area serial shifter.

Parameters:
- WIDTH, 32, register width in bits; power of two, >= 2.
- AMOUNT_WIDTH, 5, width of Amount; equals log2(WIDTH).

Ports:
- Clock  in  1  single system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  parallel load strobe; honoured only in IDLE or DONE.
- Data  in  WIDTH  parallel load value.
- Start  in  1  begin shift operation; honoured only in IDLE or DONE.
- Mode  in  3  000 hold, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110/111 hold.
- Amount  in  AMOUNT_WIDTH  number of bit positions to shift.
- Q  out  WIDTH  register contents.
- SerialOut  out  1  last bit shifted or rotated out.
- Busy  out  1  high while in SHIFT.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (sampled at a rising edge, overrides everything, including mid-operation): state IDLE; Q=0, SerialOut=0, Busy=0, Done=0, count=0. No Done for an aborted operation.
- States: IDLE, SHIFT, DONE. Busy=1 only in SHIFT; Done=1 only in DONE. Both are registered state decodes.
- IDLE/DONE, Load=1: Q<=Data. State goes to IDLE. Load has priority; a simultaneous Start is dropped.
- IDLE/DONE, Start=1, Load=0: latch Mode into mode_r and Amount into count. If Amount!=0, go to SHIFT; otherwise go to DONE with Q unchanged.
- IDLE/DONE, otherwise: DONE goes to IDLE; IDLE stays. Q holds.
- SHIFT: each edge applies one step using mode_r, then count<=count-1. When count==1 at the edge, go to DONE.
- Start, Load, Mode and Amount are ignored in SHIFT. Mode/Amount changes after acceptance have no effect.
- Latency: Start accepted at edge k with Amount=n>0. Shifts occur at edges k+1..k+n. Busy is high for n cycles. Done is high in the cycle after edge k+n.
- Back-to-back: a Start during DONE is accepted, so there is no idle bubble.
- Step rules, one position per step:
  - SLL: Q<=Q<<1, zero fill; SerialOut<=Q[WIDTH-1].
  - SRL: Q<=Q>>1, zero fill; SerialOut<=Q[0].
  - SRA: MSB replicated; SerialOut<=Q[0].
  - ROL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; SerialOut<=Q[WIDTH-1].
  - ROR: Q<={Q[0],Q[WIDTH-1:1]}; SerialOut<=Q[0].
  - Hold modes: Q and SerialOut unchanged, but count still runs and Done still pulses.
- SerialOut changes only on shift steps or reset; Load does not alter it.
- Amount range is 0..WIDTH-1 by construction; no overflow case.

Decomposition:
- Shared include file shift_defs.vh holds:
  - Mode encodings: MODE_HOLD, MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR.
  - State encodings: ST_IDLE, ST_SHIFT, ST_DONE (2-bit).
- One combinational sub-module, shift_step: params WIDTH; inputs value, mode; outputs next value and out bit. Reused by the future barrel shifter.
- Top level holds the FSM, the down-counter and the registers.

Test Plan (WIDTH=8, AMOUNT_WIDTH=3):
- Hold Reset=1 for 2 edges with Start=1 -> Q=0x00, SerialOut=0, Busy=0, Done=0.
- Load 0xB4, then Start Mode=SLL Amount=3 -> Busy=1 for exactly 3 cycles, then Done=1 for 1 cycle; Q=0xA0, SerialOut=1.
- Load 0x96, Start SRA Amount=2 -> Q=0xE5 with Done pulse 2 cycles after Busy rises; SerialOut=1.
- Load 0x81, Start ROR Amount=7 -> Q=0x03, SerialOut=0; then immediate Start during DONE, ROL Amount=1 -> Q=0x06, no IDLE cycle between.
- Load 0x5A, Start SLL Amount=0 -> Busy never high; Done=1 in the next cycle; Q stays 0x5A.
- Load 0xFF, Start SRL Amount=7; after 3 shifts check Q=0x1F; pulse Start and Load=1 Data=0x00 (both ignored), then Reset -> next edge Q=0x00, Busy=0, Done never asserted.
